// File: rtl/load_store_unit.sv
// Memory-stage load/store unit. It runs one data-memory transaction per
// instruction over a req/gnt/rvalid bus and stalls the pipeline until that
// transaction completes. It builds store byte-enables and lane data, extracts
// and extends load data, and flags misaligned or illegal accesses. A flagged
// access never reaches the bus.
module load_store_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  ValidM_i,
    input  logic                  MemReadM_i,
    input  logic                  MemWriteM_i,
    input  logic [2:0]            Funct3M_i,
    input  logic [ADDR_WIDTH-1:0] ALUResultM_i,
    input  logic [DATA_WIDTH-1:0] WriteDataM_i,
    input  logic                  HoldM_i,
    input  logic                  FlushM_i,
    output logic                  dmem_req_o,
    output logic                  dmem_we_o,
    output logic [ADDR_WIDTH-1:0] dmem_addr_o,
    output logic [3:0]            dmem_be_o,
    output logic [DATA_WIDTH-1:0] dmem_wdata_o,
    input  logic                  dmem_gnt_i,
    input  logic                  dmem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] dmem_rdata_i,
    output logic [DATA_WIDTH-1:0] ReadDataM_o,
    output logic                  StallM_o,
    output logic                  MemErrM_o
);

    // Funct3 access encodings.
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT_R = 2'd1,
        S_HOLD   = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    discard_q, discard_d;
    logic [1:0]              off_q, off_d;
    logic [2:0]              f3_q, f3_d;

    logic                    access;
    logic                    illegal;
    logic                    misaligned;
    logic                    bad_access;
    logic                    legal_access;
    logic [DATA_WIDTH-1:0]   load_fmt;
    logic                    req;
    logic                    stall;
    logic                    err;
    logic [DATA_WIDTH-1:0]   rdata_out;

    // Extract the addressed byte or half from the read word, then sign- or zero-extend it.
    function automatic logic [DATA_WIDTH-1:0] format_load(
        input logic [DATA_WIDTH-1:0] word,
        input logic [1:0]            off,
        input logic [2:0]            f3
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            F3_B:    format_load = {{24{b[7]}}, b};
            F3_BU:   format_load = {24'b0, b};
            F3_H:    format_load = {{16{h[15]}}, h};
            F3_HU:   format_load = {16'b0, h};
            default: format_load = word;
        endcase
    endfunction

    // Classify the incoming access as legal, misaligned or illegal.
    always_comb begin
        access     = ValidM_i & (MemReadM_i | MemWriteM_i) & ~FlushM_i;
        illegal    = (Funct3M_i == 3'b011) | (Funct3M_i == 3'b110) |
                     (Funct3M_i == 3'b111) | (MemWriteM_i & Funct3M_i[2]);
        misaligned = ((Funct3M_i[1:0] == 2'b10) & (ALUResultM_i[1:0] != 2'b00)) |
                     ((Funct3M_i[1:0] == 2'b01) & ALUResultM_i[0]);
        bad_access   = access & (illegal | misaligned);
        legal_access = access & ~bad_access;
    end

    // Build the store byte-enables and the lane-replicated write data. Reads enable all four lanes.
    always_comb begin
        dmem_addr_o = {ALUResultM_i[ADDR_WIDTH-1:2], 2'b00};
        case (Funct3M_i[1:0])
            2'b00: begin
                dmem_be_o    = 4'b0001 << ALUResultM_i[1:0];
                dmem_wdata_o = {4{WriteDataM_i[7:0]}};
            end
            2'b01: begin
                dmem_be_o    = ALUResultM_i[1] ? 4'b1100 : 4'b0011;
                dmem_wdata_o = {2{WriteDataM_i[15:0]}};
            end
            default: begin
                dmem_be_o    = 4'b1111;
                dmem_wdata_o = WriteDataM_i;
            end
        endcase
        if (!MemWriteM_i) begin
            dmem_be_o = 4'b1111;
        end
    end

    assign load_fmt = format_load(dmem_rdata_i, off_q, f3_q);

    // Compute the next state, the bus request and the stall and result outputs.
    always_comb begin
        // NOTE: every signal gets a default before the case so that no path
        // leaves a value unassigned, which would infer a latch.
        state_d   = state_q;
        rdata_d   = rdata_q;
        discard_d = discard_q;
        off_d     = off_q;
        f3_d      = f3_q;
        req       = 1'b0;
        stall     = 1'b0;
        err       = 1'b0;
        rdata_out = '0;

        case (state_q)
            S_IDLE: begin
                err = bad_access;
                if (legal_access) begin
                    req = 1'b1;
                    if (dmem_gnt_i) begin
                        if (MemWriteM_i) begin
                            // Store is done at grant. Park in HOLD so it is not reissued while frozen.
                            if (HoldM_i) begin
                                state_d = S_HOLD;
                            end
                        end else begin
                            stall     = 1'b1;
                            state_d   = S_WAIT_R;
                            off_d     = ALUResultM_i[1:0];
                            f3_d      = Funct3M_i;
                            discard_d = 1'b0;
                        end
                    end else begin
                        stall = 1'b1;
                    end
                end
            end

            S_WAIT_R: begin
                // The read can't be abandoned. A flush only marks its data for discard.
                if (FlushM_i) begin
                    discard_d = 1'b1;
                end
                if (dmem_rvalid_i) begin
                    discard_d = 1'b0;
                    if (discard_q | FlushM_i) begin
                        state_d = S_IDLE;
                    end else begin
                        rdata_d   = load_fmt;
                        rdata_out = load_fmt;
                        state_d   = HoldM_i ? S_HOLD : S_IDLE;
                    end
                end else begin
                    stall = 1'b1;
                end
            end

            S_HOLD: begin
                rdata_out = rdata_q;
                if (FlushM_i | ~HoldM_i) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // While reset is asserted, force the control outputs and the load result to zero.
    always_comb begin
        dmem_req_o  = req & rst_n_i;
        dmem_we_o   = req & rst_n_i & MemWriteM_i;
        StallM_o    = stall & rst_n_i;
        MemErrM_o   = err & rst_n_i;
        ReadDataM_o = rst_n_i ? rdata_out : '0;
    end

    // State and capture registers. Reset returns to IDLE with no held data.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= S_IDLE;
            rdata_q   <= '0;
            discard_q <= 1'b0;
            off_q     <= 2'b00;
            f3_q      <= 3'b000;
        end else begin
            // NOTE: non-blocking assignments, so every flop samples its pre-edge value.
            state_q   <= state_d;
            rdata_q   <= rdata_d;
            discard_q <= discard_d;
            off_q     <= off_d;
            f3_q      <= f3_d;
        end
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage load/store unit of the pipelined RV32I core, directly downstream of the execute stage. Takes the ALU result as byte address and the forwarded rs2 value as store data, runs one data-memory transaction per instruction over a request/grant/rvalid bus, and stalls the pipeline until it completes. It formats store byte-enables and lane data, extracts and extends load data, and flags misaligned or illegal accesses without touching the bus.

## Interface
- DATA_WIDTH, 32, data word width; only 32 is supported.
- ADDR_WIDTH, 32, byte address width.

- clk_i  in  1  core clock; all state changes on the rising edge.
- rst_n_i  in  1  asynchronous, active-low reset.
- ValidM_i  in  1  MEM stage holds a valid instruction.
- MemReadM_i  in  1  instruction is a load.
- MemWriteM_i  in  1  instruction is a store; never set together with MemReadM_i.
- Funct3M_i  in  3  access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- ALUResultM_i  in  ADDR_WIDTH  byte address.
- WriteDataM_i  in  DATA_WIDTH  store data, value in the low bits.
- HoldM_i  in  1  downstream or hazard stall; the pipeline advances only when StallM_o and HoldM_i are both 0.
- FlushM_i  in  1  kill the instruction in MEM.
- dmem_req_o  out  1  bus request.
- dmem_we_o  out  1  1 = write.
- dmem_addr_o  out  ADDR_WIDTH  word-aligned address, {ALUResultM_i[31:2],2'b00}.
- dmem_be_o  out  4  byte enables; 4'b1111 for reads.
- dmem_wdata_o  out  DATA_WIDTH  lane-replicated store data.
- dmem_gnt_i  in  1  request accepted this cycle.
- dmem_rvalid_i  in  1  read data valid; arrives no earlier than the cycle after grant.
- dmem_rdata_i  in  DATA_WIDTH  read word.
- ReadDataM_o  out  DATA_WIDTH  extended load result.
- StallM_o  out  1  freeze the pipeline through MEM.
- MemErrM_o  out  1  misaligned or illegal access, for the current cycle.

## Operation
- Access = ValidM_i & (MemReadM_i | MemWriteM_i) & !FlushM_i.
- Misaligned: W with addr[1:0] != 0, or H/HU with addr[0] != 0.
- Illegal: Funct3M_i 011/110/111, or a store with 100/101.
- A misaligned or illegal access:
  - Never raises dmem_req_o.
  - MemErrM_o = 1 combinationally.
  - StallM_o = 0.
  - ReadDataM_o = 0.
- Store formatting:
  - SB: be = 4'b0001 << addr[1:0]; wdata = data[7:0] replicated x4.
  - SH: be = addr[1] ? 4'b1100 : 4'b0011; wdata = data[15:0] replicated x2.
  - SW: be = 4'b1111; wdata = data.
- Load extraction: select byte addr[1:0] or half addr[1] from dmem_rdata_i.
  - B/H: sign-extend.
  - BU/HU: zero-extend.
  - Byte/half offset and funct3 are captured in a register at grant.
- FSM states:
  - IDLE: on a legal access, drive dmem_req_o = 1. With no grant, stay in IDLE; req, addr, we, be and wdata must stay stable. On a store grant, go to HOLD if HoldM_i = 1, else stay in IDLE. On a load grant, go to WAIT_R.
  - WAIT_R: dmem_req_o = 0. On dmem_rvalid_i, register the formatted data into rdata_q, then go to HOLD if HoldM_i = 1, else IDLE.
  - HOLD: the access is complete and the pipeline is frozen by HoldM_i. No request is issued. Return to IDLE when HoldM_i = 0. This prevents a duplicate transaction.
- StallM_o = 1 when any of these holds:
  - IDLE with a legal access and no grant.
  - IDLE with a load grant.
  - WAIT_R without rvalid.
- ReadDataM_o:
  - In the WAIT_R rvalid cycle: the formatted dmem_rdata_i.
  - In HOLD: rdata_q.
  - Otherwise: 0.
- FlushM_i:
  - In IDLE it suppresses the request in the same cycle.
  - In WAIT_R the bus read cannot be abandoned. A discard flag is set, StallM_o stays 1 until rvalid, the data is dropped (ReadDataM_o = 0), and the FSM goes to IDLE.
  - In HOLD, flush forces the FSM to IDLE.

## Timing
- Reset (async, rst_n_i low):
  - state = IDLE, rdata_q = 0, discard flag = 0.
  - dmem_req_o, StallM_o and MemErrM_o are forced to 0 while reset is asserted.
- Reset mid-transaction abandons it. The bus slave must drop any in-flight rvalid after its own reset.
- Store latency: 0 extra cycles if granted in the request cycle; otherwise +1 cycle per wait-state.
- Load latency: at least 1 stall cycle (grant cycle), plus rvalid wait cycles. Data is valid in the rvalid cycle.
- Back-to-back: a new access may request in the cycle after completion. There is at most one outstanding transaction.
- dmem_gnt_i and dmem_rvalid_i are ignored outside IDLE and WAIT_R respectively.

## Test plan
- SW at addr 0x100, data 0xDEADBEEF, gnt in same cycle -> one req cycle, be = 1111, wdata = 0xDEADBEEF, StallM_o = 0, no second request.
- SB at addr 0x103, data 0x000000A5, gnt after 2 wait cycles -> addr_o = 0x100, be = 1000, wdata = 0xA5A5A5A5, StallM_o = 1 for 2 cycles, request stable throughout.
- LB at addr 0x102, rdata 0x12F45678, rvalid 1 cycle after grant -> ReadDataM_o = 0xFFFFFFF4. LBU at the same address -> 0x000000F4. LHU at addr 0x102 -> 0x000012F4.
- LW at addr 0x101 -> MemErrM_o = 1, dmem_req_o never asserted, StallM_o = 0. SH with funct3 101 -> MemErrM_o = 1.
- LW completes while HoldM_i = 1 for 3 cycles -> FSM in HOLD, ReadDataM_o holds the value, no re-request. Release the hold -> IDLE.
- FlushM_i during WAIT_R -> stall held until rvalid, ReadDataM_o = 0 in that cycle. rst_n_i low in WAIT_R -> all outputs 0 immediately, IDLE after release.
